// File: rtl/zmc_alu_ctrl.sv
// ---------------------------------------------------------------------------
// zmc_alu_ctrl
// Issue controller between the instruction sequencer and the 16-bit ALU.
// Takes one operation at a time, holds the opcode on the ALU for the whole
// operation, completes single-cycle ops in one EXEC cycle, waits on the ALU
// valid strobe for mul/div ops (with a timeout), owns the architectural flag
// register, and returns result/flags/error over a valid/ready response port.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_a, req_b, req_op        operands and opcode (op[7:6]==2'b11 -> mul/div)
//   req_flag_we                 commit op flags to flag register on success
//   rsp_valid/rsp_ready         response handshake
//   rsp_lo, rsp_hi              result halves (hi = 0 for single-cycle ops)
//   rsp_flags, rsp_err          {Z,S,C,OVR} of the op, mul/div timeout
//   flags_out, busy             flag register, state != IDLE
//   alu_*_out                   operands/opcode/flag register to the ALU
//   alu_*_in                    result, flags and valid strobe from the ALU
// ---------------------------------------------------------------------------
module zmc_alu_ctrl #(
  parameter int                DATA_WL = 16,
  parameter int                OP_WL   = 8,
  parameter logic [OP_WL-1:0]  NOP_OP  = 8'h00,
  parameter int                TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  // request
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [DATA_WL-1:0] req_a,
  input  logic [DATA_WL-1:0] req_b,
  input  logic [OP_WL-1:0]   req_op,
  input  logic               req_flag_we,
  // response
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_WL-1:0] rsp_lo,
  output logic [DATA_WL-1:0] rsp_hi,
  output logic [3:0]         rsp_flags,
  output logic               rsp_err,
  // status
  output logic [3:0]         flags_out,
  output logic               busy,
  // to ALU
  output logic [DATA_WL-1:0] alu_a_out,
  output logic [DATA_WL-1:0] alu_b_out,
  output logic [OP_WL-1:0]   alu_op_out,
  output logic               alu_z_flag_out,
  output logic               alu_s_flag_out,
  output logic               alu_c_flag_out,
  output logic               alu_ovr_flag_out,
  // from ALU
  input  logic [DATA_WL-1:0] alu_c_in,
  input  logic               alu_z_flag_in,
  input  logic               alu_s_flag_in,
  input  logic               alu_c_flag_in,
  input  logic               alu_ovr_flag_in,
  input  logic               alu_valid_in
);

  // Counter is at least 7 bits and always wide enough for TIMEOUT-1.
  localparam int CNT_W = ($clog2(TIMEOUT) > 7) ? $clog2(TIMEOUT) : 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_WAIT_MD = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             state_q;
  logic [DATA_WL-1:0] a_q, b_q;
  logic [OP_WL-1:0]   alu_op_q;
  logic               we_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_WL-1:0] prev_q;
  logic [DATA_WL-1:0] lo_q, hi_q;
  logic [3:0]         rflags_q;
  logic               err_q;
  logic [3:0]         flags_q;

  logic [3:0]         alu_flags;
  logic               req_is_md;

  assign alu_flags = {alu_z_flag_in, alu_s_flag_in, alu_c_flag_in, alu_ovr_flag_in};
  assign req_is_md = (req_op[OP_WL-1:OP_WL-2] == 2'b11);

  // Saturating increment; the FSM leaves WAIT_MD at CNT_LAST so saturation
  // only matters if TIMEOUT is set right at the counter's range.
  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      alu_op_q <= NOP_OP;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      prev_q   <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      rflags_q <= '0;
      err_q    <= 1'b0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            a_q      <= req_a;
            b_q      <= req_b;
            alu_op_q <= req_op;   // opcode stays on the ALU until completion
            we_q     <= req_flag_we;
            cnt_q    <= '0;
            state_q  <= req_is_md ? S_WAIT_MD : S_EXEC;
          end
        end
        S_EXEC: begin
          lo_q     <= alu_c_in;
          hi_q     <= '0;
          rflags_q <= alu_flags;
          err_q    <= 1'b0;
          if (we_q) flags_q <= alu_flags;
          alu_op_q <= NOP_OP;
          state_q  <= S_DONE;
        end
        S_WAIT_MD: begin
          // ALU presents the low half the cycle before it raises valid with
          // the high half, so keep one cycle of history.
          prev_q <= alu_c_in;
          if (alu_valid_in) begin
            hi_q     <= alu_c_in;
            lo_q     <= prev_q;
            rflags_q <= alu_flags;
            err_q    <= 1'b0;
            if (we_q) flags_q <= alu_flags;
            alu_op_q <= NOP_OP;
            state_q  <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            // Abort: zero result, error set, flag register untouched.
            hi_q     <= '0;
            lo_q     <= '0;
            rflags_q <= '0;
            err_q    <= 1'b1;
            alu_op_q <= NOP_OP;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          if (rsp_ready) state_q <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          alu_op_q <= NOP_OP;
        end
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_lo    = lo_q;
  assign rsp_hi    = hi_q;
  assign rsp_flags = rflags_q;
  assign rsp_err   = err_q;
  assign flags_out = flags_q;

  assign alu_a_out        = a_q;
  assign alu_b_out        = b_q;
  assign alu_op_out       = alu_op_q;
  assign alu_z_flag_out   = flags_q[3];
  assign alu_s_flag_out   = flags_q[2];
  assign alu_c_flag_out   = flags_q[1];
  assign alu_ovr_flag_out = flags_q[0];

endmodule

// File: tb/tb_zmc_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_zmc_alu_ctrl
// Directed bench for zmc_alu_ctrl with a behavioural ALU stub. Expected
// responses are queued when a request is driven and popped when the DUT
// raises rsp_valid. Inputs change and outputs are sampled #1 after posedge.
// ---------------------------------------------------------------------------
module tb_zmc_alu_ctrl;
  localparam int         DW      = 16;
  localparam int         OW      = 8;
  localparam logic [7:0] NOP     = 8'h00;
  localparam int         TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_flag_we;
  logic [DW-1:0] req_a, req_b;
  logic [OW-1:0] req_op;
  logic          rsp_valid, rsp_ready, rsp_err, busy;
  logic [DW-1:0] rsp_lo, rsp_hi;
  logic [3:0]    rsp_flags, flags_out;
  logic [DW-1:0] alu_a_out, alu_b_out, alu_c_in;
  logic [OW-1:0] alu_op_out;
  logic          alu_z_flag_out, alu_s_flag_out, alu_c_flag_out, alu_ovr_flag_out;
  logic          alu_z_flag_in, alu_s_flag_in, alu_c_flag_in, alu_ovr_flag_in, alu_valid_in;

  always #5 clk = ~clk;

  zmc_alu_ctrl #(.DATA_WL(DW), .OP_WL(OW), .NOP_OP(NOP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_flag_we(req_flag_we),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .flags_out(flags_out), .busy(busy),
    .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_op_out(alu_op_out),
    .alu_z_flag_out(alu_z_flag_out), .alu_s_flag_out(alu_s_flag_out),
    .alu_c_flag_out(alu_c_flag_out), .alu_ovr_flag_out(alu_ovr_flag_out),
    .alu_c_in(alu_c_in),
    .alu_z_flag_in(alu_z_flag_in), .alu_s_flag_in(alu_s_flag_in),
    .alu_c_flag_in(alu_c_flag_in), .alu_ovr_flag_in(alu_ovr_flag_in),
    .alu_valid_in(alu_valid_in)
  );

  // ---------------- ALU stub ----------------
  // op 8'h01: a+b, combinational. op 8'hC0: product, low half on cycle 4,
  // high half with valid on cycle 5 (cycle 1 = first cycle the op is seen).
  // Once started, the mul sequence runs to cycle 5 regardless of the DUT.
  // Any other mul/div-class op never answers.
  logic        md_run = 1'b0;
  logic [2:0]  md_cnt = 3'd0;
  logic [2:0]  md_cyc;
  logic [31:0] prod;
  logic [16:0] sum;

  assign prod   = {16'h0, alu_a_out} * {16'h0, alu_b_out};
  assign sum    = {1'b0, alu_a_out} + {1'b0, alu_b_out};
  assign md_cyc = md_run ? md_cnt : ((alu_op_out == 8'hC0) ? 3'd1 : 3'd0);

  always @(posedge clk) begin
    if (!md_run) begin
      if (alu_op_out == 8'hC0) begin
        md_run <= 1'b1;
        md_cnt <= 3'd2;
      end
    end else if (md_cnt == 3'd5) begin
      md_run <= 1'b0;
    end else begin
      md_cnt <= md_cnt + 3'd1;
    end
  end

  always_comb begin
    alu_c_in        = 16'hDEAD;
    alu_z_flag_in   = 1'b0;
    alu_s_flag_in   = 1'b0;
    alu_c_flag_in   = 1'b0;
    alu_ovr_flag_in = 1'b0;
    alu_valid_in    = 1'b0;
    if (md_cyc == 3'd4) begin
      alu_c_in = prod[15:0];
    end else if (md_cyc == 3'd5) begin
      alu_c_in      = prod[31:16];
      alu_valid_in  = 1'b1;
      alu_z_flag_in = (prod == 32'h0);
      alu_s_flag_in = prod[31];
    end else if (alu_op_out == 8'h01) begin
      alu_c_in        = sum[15:0];
      alu_z_flag_in   = (sum[15:0] == 16'h0);
      alu_s_flag_in   = sum[15];
      alu_c_flag_in   = sum[16];
      alu_ovr_flag_in = (alu_a_out[15] == alu_b_out[15]) && (sum[15] != alu_a_out[15]);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  flags;
    logic        err;
    logic        we;
    int          lat;   // cycles from the accept cycle N to the first rsp_valid cycle
  } rsp_t;

  rsp_t       sb[$];
  logic [3:0] flags_model = 4'h0;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic rsp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [7:0] op, input logic we);
    rsp_t        r;
    logic [16:0] s;
    logic [31:0] p;
    r.we = we;
    if (op == 8'h01) begin
      s       = {1'b0, a} + {1'b0, b};
      r.lo    = s[15:0];
      r.hi    = 16'h0;
      r.flags = {s[15:0] == 16'h0, s[15], s[16], (a[15] == b[15]) && (s[15] != a[15])};
      r.err   = 1'b0;
      r.lat   = 2;                 // EXEC in N+1, DONE in N+2
    end else if (op == 8'hC0) begin
      p       = {16'h0, a} * {16'h0, b};
      r.lo    = p[15:0];
      r.hi    = p[31:16];
      r.flags = {p == 32'h0, p[31], 1'b0, 1'b0};
      r.err   = 1'b0;
      r.lat   = 6;                 // valid sampled at end of WAIT cycle 5
    end else begin
      r.lo    = 16'h0;
      r.hi    = 16'h0;
      r.flags = 4'h0;
      r.err   = 1'b1;
      r.lat   = TIMEOUT + 1;       // DONE exactly TIMEOUT cycles after WAIT entry
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request from IDLE; returns just after the accept edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [7:0] op, input logic we, input logic push);
    req_a = a; req_b = b; req_op = op; req_flag_we = we; req_valid = 1'b1;
    if (push) sb.push_back(model(a, b, op, we));
    chk("req_ready_at_accept", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Called in cycle N+1. Waits (bounded) for rsp_valid and compares.
  task automatic get_rsp(input string tag, input logic [7:0] op);
    rsp_t e;
    int   lat = 1;
    while (!rsp_valid && lat < 200) begin
      chk({tag, "_op_hold"}, {24'h0, alu_op_out}, {24'h0, op});
      chk({tag, "_flags_before"}, {28'h0, flags_out}, {28'h0, flags_model});
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_sb_nonempty"}, {31'h0, sb.size() != 0}, 32'h1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
    chk({tag, "_op_nop"}, {24'h0, alu_op_out}, {24'h0, NOP});
    chk({tag, "_lo"}, {16'h0, rsp_lo}, {16'h0, e.lo});
    chk({tag, "_hi"}, {16'h0, rsp_hi}, {16'h0, e.hi});
    chk({tag, "_flags"}, {28'h0, rsp_flags}, {28'h0, e.flags});
    chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, e.err});
    if (e.we && !e.err) flags_model = e.flags;
    chk({tag, "_flags_out"}, {28'h0, flags_out}, {28'h0, flags_model});
    chk({tag, "_alu_flag_bits"},
        {28'h0, alu_z_flag_out, alu_s_flag_out, alu_c_flag_out, alu_ovr_flag_out},
        {28'h0, flags_model});
  endtask

  task automatic release_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_idle_valid"}, {31'h0, rsp_valid}, 32'h0);
    chk({tag, "_idle_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_idle_ready"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    req_flag_we = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_rsp_data", {rsp_hi, rsp_lo}, 32'h0);
    chk("rst_rsp_flags", {28'h0, rsp_flags}, 32'h0);
    chk("rst_flags_out", {28'h0, flags_out}, 32'h0);
    chk("rst_alu_op", {24'h0, alu_op_out}, {24'h0, NOP});
    chk("rst_alu_ab", {alu_a_out, alu_b_out}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // single-cycle add with overflow, flags committed
    send(16'h7FFF, 16'h0001, 8'h01, 1'b1, 1'b1);
    get_rsp("add", 8'h01);
    chk("add_lo_const", {16'h0, rsp_lo}, 32'h8000);
    chk("add_flags_out_const", {28'h0, flags_out}, 32'h5);
    release_rsp("add");

    // timeout on an op the stub never answers; flags_out must not move
    send(16'h0005, 16'h0006, 8'hC1, 1'b1, 1'b1);
    get_rsp("tmo", 8'hC1);
    chk("tmo_flags_out_const", {28'h0, flags_out}, 32'h5);
    release_rsp("tmo");

    // zero result with flag_we=0
    send(16'h0000, 16'h0000, 8'h01, 1'b0, 1'b1);
    get_rsp("zero", 8'h01);
    chk("zero_rsp_flags_const", {28'h0, rsp_flags}, 32'h8);
    chk("zero_flags_out_const", {28'h0, flags_out}, 32'h5);
    release_rsp("zero");

    // mul via two-phase ALU response
    send(16'h1234, 16'h0100, 8'hC0, 1'b1, 1'b1);
    get_rsp("mul", 8'hC0);
    chk("mul_result_const", {rsp_hi, rsp_lo}, 32'h0012_3400);
    release_rsp("mul");

    // backpressure: second request held on the port while response stalls
    send(16'h1111, 16'h2222, 8'h01, 1'b1, 1'b1);
    req_a = 16'h8000; req_b = 16'h8000; req_op = 8'h01; req_flag_we = 1'b1;
    req_valid = 1'b1;
    sb.push_back(model(16'h8000, 16'h8000, 8'h01, 1'b1));
    get_rsp("bp1", 8'h01);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_hold", {31'h0, rsp_valid}, 32'h1);
      chk("bp_lo_hold", {16'h0, rsp_lo}, 32'h3333);
      chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_idle_ready", {31'h0, req_ready}, 32'h1);
    chk("bp_idle_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_second_accepted", {31'h0, busy}, 32'h1);
    get_rsp("bp2", 8'h01);
    chk("bp2_flags_out_const", {28'h0, flags_out}, 32'hB);
    release_rsp("bp2");

    // reset during WAIT_MD; stub's late valid must be ignored
    send(16'h0003, 16'h0004, 8'hC0, 1'b1, 1'b0);
    @(posedge clk); #1;          // now in WAIT cycle 2
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    flags_model = 4'h0;
    chk("rstmd_busy", {31'h0, busy}, 32'h0);
    chk("rstmd_op_nop", {24'h0, alu_op_out}, {24'h0, NOP});
    chk("rstmd_flags_out", {28'h0, flags_out}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk("rstmd_no_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rstmd_stay_idle", {31'h0, req_ready}, 32'h1);
      @(posedge clk); #1;
    end
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
